// File: rtl/dcpu_inst_mem_loader.sv
// Instruction memory for the D-CPU: combinational fetch port for the core plus a
// host byte-stream loader (high byte first) that writes 16-bit words while the core is held.
`timescale 1ns/1ps
module dcpu_inst_mem_loader #(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = 16'h0000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] InstMemAddr,
    output logic [15:0]       Inst,
    input  logic              LdStart,
    input  logic [ADDR_W-1:0] LdBase,
    input  logic [ADDR_W:0]   LdCount,
    input  logic              ByteValid,
    input  logic [7:0]        ByteData,
    output logic              ByteReady,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              err_d;
    logic              busy_q, ready_q, done_q, err_q;
    logic              byte_acc_s;
    logic              wr_en_s;

    logic [15:0]       mem_q [DEPTH];

    assign byte_acc_s = ByteValid & ready_q;

    // Next-state, load bookkeeping and reject detection
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        err_d   = 1'b0;
        wr_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (LdStart) begin
                    if (LdCount != CNT_ZERO) begin
                        addr_d  = LdBase;
                        cnt_d   = LdCount;
                        state_d = ST_HI;
                    end else begin
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HI: begin
                err_d = LdStart;
                if (byte_acc_s) begin
                    hi_d    = ByteData;
                    state_d = ST_LO;
                end else begin
                    state_d = ST_HI;
                end
            end
            ST_LO: begin
                err_d = LdStart;
                if (byte_acc_s) begin
                    wr_en_s = 1'b1;
                    // Address wraps naturally at 2^ADDR_W
                    addr_d  = addr_q + ADDR_ONE;
                    cnt_d   = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_HI;
                    end
                end else begin
                    state_d = ST_LO;
                end
            end
            ST_DONE: begin
                err_d   = LdStart;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered status outputs, decoded from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= ADDR_ZERO;
            cnt_q   <= CNT_ZERO;
            hi_q    <= 8'h00;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            busy_q  <= (state_d != ST_IDLE);
            ready_q <= (state_d == ST_HI) || (state_d == ST_LO);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
        end
    end

    // Word write; the array is deliberately not reset so program contents survive RST
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_q[addr_q] <= {hi_q, ByteData};
        end
    end

    // Fetch port: NOP while a load is in progress so the core never sees a half-written program
    always_comb begin
        if (busy_q) begin
            Inst = NOP_WORD;
        end else begin
            Inst = mem_q[InstMemAddr];
        end
    end

    assign ByteReady = ready_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule
